mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Initiator side of the single-port 8-bit memory interface: drives mem_we, mem_addr and mem_wdata, and samples mem_rdata.
- Copies a block of bytes from a source region to a destination region of the same memory, or fills a region with a constant pattern.
- Sits between the control/sequencer logic and the data memory. Used for block moves and memory clearing, so no CPU load/store loop is needed.

Parameters:
- AW, 8, address width; also the width of the length and count fields.
- DW, 8, data width.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request a transfer; sampled only in IDLE
- mode  input  1  0 = copy src→dst, 1 = fill dst with pattern
- src  input  AW  source start address (ignored in fill mode)
- dst  input  AW  destination start address
- len  input  AW  byte count, 0..2^AW-1
- pattern  input  DW  fill value
- abort  input  1  terminate the running transfer early
- busy  output  1  high while a transfer is in progress
- done  output  1  one-cycle pulse at the end of a transfer
- xfer_cnt  output  AW  bytes written by the current or last transfer
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data; combinational from mem_addr in the same cycle

Behaviour:
- Reset: rst_n=0 at a rising edge sends the FSM to IDLE from any state, including mid-transfer.
  - Reset values: busy=0, done=0, xfer_cnt=0, mem_we=0, mem_addr=0, mem_wdata=0, data buffer=0.
  - No partial write is issued after the reset edge.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - Outputs: mem_we=0, mem_addr=0, busy=0.
  - On start=1: latch src, dst, len, mode and pattern; clear xfer_cnt.
  - Next state: FIN if len=0; otherwise WR if mode=1, or RD if mode=0.
- RD (copy only):
  - Drive mem_addr=src_q+xfer_cnt (mod 2^AW), mem_we=0.
  - At the edge, capture mem_rdata into the data buffer, then go to WR.
- WR:
  - Drive mem_addr=dst_q+xfer_cnt (mod 2^AW), mem_we=1.
  - mem_wdata is the buffer in copy mode, or pattern_q in fill mode.
  - At the edge, increment xfer_cnt.
  - Next state: FIN if the new xfer_cnt equals len_q or abort=1; otherwise RD (copy) or WR (fill).
- FIN: done=1 and busy=0 for exactly one cycle, then go to IDLE.
- busy=1 exactly in RD and WR.
- Outputs are decoded from registered state and counters only; there is no combinational path from start or abort to mem_*.
- Latency, measured from the start edge to the done cycle:
  - copy: 2*len+1 cycles
  - fill: len+1 cycles
  - len=0: done in the cycle immediately after the start edge, with no memory access.
- Address wrap: both src_q+i and dst_q+i wrap modulo 2^AW, e.g. dst=0xFE, len=4 writes FE, FF, 00, 01.
- Overlap: the copy is strictly forward, byte by byte in ascending order. If dst lies in (src, src+len), already-copied bytes are re-read; this behaviour is defined and accepted, not an error.
- start while busy or in FIN is ignored, and the inputs are not re-latched. Inputs may change freely after the start edge.
- abort:
  - Honoured only in RD and WR.
  - In RD: go to FIN with no write; xfer_cnt unchanged.
  - In WR: the write of that cycle completes (the memory samples at the same edge), xfer_cnt increments, then go to FIN.
  - abort in IDLE or FIN has no effect.
- Simultaneous start and abort in IDLE: start wins.
- xfer_cnt holds its final value after done until the next accepted start.
- Maximum len is 2^AW-1 = 255; xfer_cnt never wraps within a transfer.

Test Plan:
- Copy: preload mem[0x10..0x13]=A1,B2,C3,D4; start mode=0, src=0x10, dst=0x40, len=4 → mem[0x40..0x43]=A1,B2,C3,D4; done pulses 9 cycles after the start edge; busy high for 8 cycles; xfer_cnt=4.
- Fill with wrap: mode=1, dst=0xFE, len=4, pattern=0x5A → mem[FE], mem[FF], mem[00], mem[01]=0x5A; mem[02] unchanged; done 5 cycles after start; exactly 4 mem_we cycles.
- Zero length: start with len=0 → no mem_we asserted; done the cycle after start; xfer_cnt=0; busy never high.
- Abort: copy len=10, assert abort during the 3rd WR cycle → exactly 3 bytes written; xfer_cnt=3; done next cycle. Repeat with abort in an RD cycle → no extra write.
- Reset mid-transfer: rst_n=0 during WR of byte 2 of a fill len=8 → at the reset edge all outputs are 0 and the FSM is in IDLE; with rst_n=1 held, no further writes occur and a new start runs normally.
- Start while busy: pulse start with different src/dst during a running copy → ignored; the original transfer completes with the originally latched parameters.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Block copy / fill engine for a single-port byte memory.
// Copies read-then-write per byte; fills write one byte per cycle.
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] pattern,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] xfer_cnt,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]    r_state;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW-1:0] r_len;
    logic          r_mode;
    logic [DW-1:0] r_pat;
    logic [DW-1:0] r_buf;
    logic [AW-1:0] r_cnt;

    logic [AW-1:0] w_cnt_nxt;
    logic          w_last;

    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_last    = (w_cnt_nxt == r_len) || abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_mode  <= 1'b0;
            r_pat   <= '0;
            r_buf   <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src  <= src;
                        r_dst  <= dst;
                        r_len  <= len;
                        r_mode <= mode;
                        r_pat  <= pattern;
                        r_cnt  <= '0;
                        if (len == '0)
                            r_state <= S_FIN;
                        else if (mode)
                            r_state <= S_WR;
                        else
                            r_state <= S_RD;
                    end
                end
                S_RD: begin
                    // An abort here leaves the count untouched: no write issued
                    if (abort) begin
                        r_state <= S_FIN;
                    end else begin
                        r_buf   <= mem_rdata;
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_last)
                        r_state <= S_FIN;
                    else if (r_mode)
                        r_state <= S_WR;
                    else
                        r_state <= S_RD;
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (r_state)
            S_RD: begin
                busy     = 1'b1;
                mem_addr = r_src + r_cnt;
            end
            S_WR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_dst + r_cnt;
                mem_wdata = r_mode ? r_pat : r_buf;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural byte memory.
// Cycle 1 is the cycle right after the start edge.
module tb_mem_copy_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic [7:0] pattern;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] xfer_cnt;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] mem [256];
    int         we_cnt = 0;
    logic       ld_en = 1'b0;
    logic       clr_en = 1'b0;
    logic [7:0] ld_addr = 8'h00;
    logic [7:0] ld_data = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_copy_engine #(.AW(8), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .pattern   (pattern),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .xfer_cnt  (xfer_cnt),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (clr_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (mem_we === 1'b1) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic clear_mem();
        @(negedge clk);
        clr_en = 1'b1;
        @(negedge clk);
        clr_en = 1'b0;
    endtask

    // Returns at the negedge of cycle 1
    task automatic kick(input logic m, input logic [7:0] s,
                        input logic [7:0] d, input logic [7:0] l,
                        input logic [7:0] p, input logic ab);
        @(negedge clk);
        mode = m; src = s; dst = d; len = l; pattern = p;
        abort = ab; start = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    // Entered at the negedge of cycle c0; cyc=-1 on timeout
    task automatic wait_done(input int c0, output int cyc, output int bsy);
        cyc = -1;
        bsy = 0;
        for (int c = c0; c <= 600; c++) begin
            if (busy === 1'b1) bsy++;
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, mem_we} !== 3'b000) begin
            $display("FAIL reset_flags: got %b want 000", {busy, done, mem_we});
            n_bad++;
        end
        n_cmp++;
        if ({xfer_cnt, mem_addr, mem_wdata} !== 24'h0) begin
            $display("FAIL reset_buses: got %h want 000000",
                     {xfer_cnt, mem_addr, mem_wdata});
            n_bad++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_copy();
        int cyc, bsy, w0;
        load(8'h10, 8'hA1); load(8'h11, 8'hB2);
        load(8'h12, 8'hC3); load(8'h13, 8'hD4);
        w0 = we_cnt;
        kick(1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 1'b0);
        wait_done(1, cyc, bsy);
        n_cmp++;
        if (cyc !== 9) begin
            $display("FAIL copy_latency: got %0d want 9", cyc); n_bad++;
        end
        n_cmp++;
        if (bsy !== 8) begin
            $display("FAIL copy_busy: got %0d want 8", bsy); n_bad++;
        end
        n_cmp++;
        if (xfer_cnt !== 8'd4) begin
            $display("FAIL copy_cnt: got %0d want 4", xfer_cnt); n_bad++;
        end
        n_cmp++;
        if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== 32'hA1B2C3D4) begin
            $display("FAIL copy_data: got %h want a1b2c3d4",
                     {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]});
            n_bad++;
        end
        n_cmp++;
        if (we_cnt - w0 !== 4) begin
            $display("FAIL copy_writes: got %0d want 4", we_cnt - w0); n_bad++;
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({done, busy, xfer_cnt} !== {2'b00, 8'd4}) begin
            $display("FAIL copy_hold: got %h want 004", {done, busy, xfer_cnt});
            n_bad++;
        end
    endtask

    task automatic test_fill_wrap();
        int cyc, bsy, w0;
        load(8'h02, 8'h77);
        w0 = we_cnt;
        // abort with start in IDLE must not block the start
        kick(1'b1, 8'h33, 8'hFE, 8'd4, 8'h5A, 1'b1);
        wait_done(1, cyc, bsy);
        n_cmp++;
        if (cyc !== 5) begin
            $display("FAIL fill_latency: got %0d want 5", cyc); n_bad++;
        end
        n_cmp++;
        if (we_cnt - w0 !== 4) begin
            $display("FAIL fill_writes: got %0d want 4", we_cnt - w0); n_bad++;
        end
        n_cmp++;
        if ({mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01], mem[8'h02]}
            !== 40'h5A5A5A5A77) begin
            $display("FAIL fill_data: got %h want 5a5a5a5a77",
                     {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01], mem[8'h02]});
            n_bad++;
        end
        n_cmp++;
        if (xfer_cnt !== 8'd4) begin
            $display("FAIL fill_cnt: got %0d want 4", xfer_cnt); n_bad++;
        end
    endtask

    task automatic test_zero_len();
        int cyc, bsy, w0;
        w0 = we_cnt;
        kick(1'b0, 8'h10, 8'h40, 8'd0, 8'h00, 1'b0);
        wait_done(1, cyc, bsy);
        n_cmp++;
        if (cyc !== 1 || bsy !== 0) begin
            $display("FAIL zero_timing: got cyc=%0d busy=%0d want 1/0", cyc, bsy);
            n_bad++;
        end
        @(negedge clk);
        n_cmp++;
        if (we_cnt - w0 !== 0 || xfer_cnt !== 8'd0) begin
            $display("FAIL zero_effect: got w=%0d cnt=%0d want 0/0",
                     we_cnt - w0, xfer_cnt);
            n_bad++;
        end
    endtask

    task automatic test_overlap();
        int cyc, bsy;
        load(8'h50, 8'h11); load(8'h51, 8'h22);
        load(8'h52, 8'h33); load(8'h53, 8'h44);
        kick(1'b0, 8'h50, 8'h51, 8'd3, 8'h00, 1'b0);
        wait_done(1, cyc, bsy);
        n_cmp++;
        if (cyc !== 7) begin
            $display("FAIL ovl_latency: got %0d want 7", cyc); n_bad++;
        end
        n_cmp++;
        if ({mem[8'h50], mem[8'h51], mem[8'h52], mem[8'h53]} !== 32'h11111111) begin
            $display("FAIL ovl_data: got %h want 11111111",
                     {mem[8'h50], mem[8'h51], mem[8'h52], mem[8'h53]});
            n_bad++;
        end
    endtask

    task automatic test_abort();
        int w0;
        for (int i = 0; i < 10; i++) load(8'h20 + 8'(i), 8'h30 + 8'(i));
        w0 = we_cnt;
        kick(1'b0, 8'h20, 8'h60, 8'd10, 8'h00, 1'b0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({mem_we, mem_addr} !== {1'b1, 8'h62}) begin
            $display("FAIL abwr_phase: got %h want 162", {mem_we, mem_addr});
            n_bad++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({done, xfer_cnt} !== {1'b1, 8'd3}) begin
            $display("FAIL abwr_end: got %h want 103", {done, xfer_cnt});
            n_bad++;
        end
        n_cmp++;
        if (we_cnt - w0 !== 3 || mem[8'h62] !== 8'h32 || mem[8'h63] !== 8'h00) begin
            $display("FAIL abwr_mem: got w=%0d m62=%h m63=%h want 3/32/00",
                     we_cnt - w0, mem[8'h62], mem[8'h63]);
            n_bad++;
        end
        w0 = we_cnt;
        kick(1'b0, 8'h20, 8'h70, 8'd10, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({mem_we, mem_addr} !== {1'b0, 8'h22}) begin
            $display("FAIL abrd_phase: got %h want 022", {mem_we, mem_addr});
            n_bad++;
        end
        abort = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({done, xfer_cnt} !== {1'b1, 8'd2}) begin
            $display("FAIL abrd_end: got %h want 102", {done, xfer_cnt});
            n_bad++;
        end
        @(negedge clk);
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if (we_cnt - w0 !== 2 || mem[8'h72] !== 8'h00 || busy !== 1'b0
            || xfer_cnt !== 8'd2) begin
            $display("FAIL abrd_mem: got w=%0d m72=%h busy=%b cnt=%0d want 2/00/0/2",
                     we_cnt - w0, mem[8'h72], busy, xfer_cnt);
            n_bad++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bsy, w0;
        w0 = we_cnt;
        kick(1'b1, 8'h00, 8'hA0, 8'd8, 8'hC3, 1'b0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_we, mem_addr} !== {1'b1, 8'hA2}) begin
            $display("FAIL rst_phase: got %h want 1a2", {mem_we, mem_addr});
            n_bad++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, mem_we, xfer_cnt, mem_addr, mem_wdata} !== 27'h0) begin
            $display("FAIL rst_outs: got %h want 0",
                     {busy, done, mem_we, xfer_cnt, mem_addr, mem_wdata});
            n_bad++;
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (we_cnt - w0 !== 3 || mem[8'hA3] !== 8'h00 || busy !== 1'b0) begin
            $display("FAIL rst_quiet: got w=%0d mA3=%h busy=%b want 3/00/0",
                     we_cnt - w0, mem[8'hA3], busy);
            n_bad++;
        end
        kick(1'b1, 8'h00, 8'hB0, 8'd2, 8'h99, 1'b0);
        wait_done(1, cyc, bsy);
        n_cmp++;
        if (cyc !== 3 || mem[8'hB0] !== 8'h99 || mem[8'hB1] !== 8'h99) begin
            $display("FAIL rst_restart: got cyc=%0d b0=%h b1=%h want 3/99/99",
                     cyc, mem[8'hB0], mem[8'hB1]);
            n_bad++;
        end
    endtask

    task automatic test_start_busy();
        int cyc, bsy, w0;
        w0 = we_cnt;
        kick(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        mode = 1'b1; src = 8'h20; dst = 8'h90; len = 8'd1;
        pattern = 8'hEE; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, cyc, bsy);
        n_cmp++;
        if (cyc !== 9 || xfer_cnt !== 8'd4) begin
            $display("FAIL sb_timing: got cyc=%0d cnt=%0d want 9/4", cyc, xfer_cnt);
            n_bad++;
        end
        n_cmp++;
        if ({mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83], mem[8'h90]}
            !== 40'hA1B2C3D400) begin
            $display("FAIL sb_data: got %h want a1b2c3d400",
                     {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83], mem[8'h90]});
            n_bad++;
        end
        n_cmp++;
        if (we_cnt - w0 !== 4) begin
            $display("FAIL sb_writes: got %0d want 4", we_cnt - w0); n_bad++;
        end
    endtask

    initial begin
        start = 1'b0; mode = 1'b0; src = 8'h00; dst = 8'h00;
        len = 8'h00; pattern = 8'h00; abort = 1'b0; rst_n = 1'b0;
        test_reset();
        clear_mem();
        test_copy();
        test_fill_wrap();
        test_zero_len();
        test_overlap();
        test_abort();
        test_reset_mid();
        test_start_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
